// File: rtl/wb_commit_tracer_if.sv
// Commit-side and trace-stream handshake signals of the WB commit tracer.
// slave is the tracer's view; master is the pipeline/consumer view.
interface wb_commit_tracer_if #(
  parameter int CYC_W = 16
) ();
  logic             reg_write_WB;
  logic [4:0]       write_register_addr_WB;
  logic [31:0]      write_back_data_WB;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_addr;
  logic [31:0]      out_data;
  logic [CYC_W-1:0] out_cycle;

  modport slave (
    input  reg_write_WB, write_register_addr_WB, write_back_data_WB, out_ready,
    output out_valid, out_addr, out_data, out_cycle
  );

  modport master (
    output reg_write_WB, write_register_addr_WB, write_back_data_WB, out_ready,
    input  out_valid, out_addr, out_data, out_cycle
  );
endinterface

// File: rtl/wb_commit_tracer.sv
// Captures nonzero-register WB commits into a cycle-stamped FIFO for an
// external consumer; full-FIFO commits are dropped and counted.
module wb_commit_tracer #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_commit_tracer_if.slave        bus,
  input  logic                     trace_en,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int EW    = CYC_W + 37;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic             capture_s, full_s, pop_s, push_s, drop_s;
  logic [EW-1:0]    entry_s, head_s;

  // Capture qualification and push/pop/drop decisions for this cycle
  always_comb begin
    capture_s = bus.reg_write_WB && (bus.write_register_addr_WB != 5'd0) && trace_en;
    full_s    = (count_q == CNT_W'(DEPTH));
    pop_s     = out_valid_q && bus.out_ready;
    push_s    = capture_s && (!full_s || pop_s);
    drop_s    = capture_s && full_s && !pop_s;
    entry_s   = {cyc_q, bus.write_register_addr_WB, bus.write_back_data_WB};
  end

  // Next-state for pointers, occupancy, overflow bookkeeping and cycle stamp
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    cyc_d        = cyc_q + CYC_W'(1);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    out_valid_d = (count_d != CNT_W'(0));

    // A drop in the same cycle as a clear restarts the tally at one
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_count_d = 8'd1;
      end else if (drop_count_q != 8'd255) begin
        drop_count_d = drop_count_q + 8'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else if (clr_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
      cyc_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      cyc_q        <= cyc_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign head_s        = mem_q[rd_ptr_q];
  assign bus.out_valid = out_valid_q;
  assign bus.out_cycle = head_s[EW-1 -: CYC_W];
  assign bus.out_addr  = head_s[36:32];
  assign bus.out_data  = head_s[31:0];
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_count_q;

endmodule

// File: doc/wb_commit_tracer.md
WB_COMMIT_TRACER -- requirements
Module: wb_commit_tracer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, trace FIFO entries; power of two, 4..256.
REQ-002 The block SHALL have parameter CYC_W, default 16, cycle-stamp width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset); one clock, synchronous active-low reset.
REQ-005 reg_write_WB  input  1  WB-stage register write enable from the pipeline.
REQ-006 write_register_addr_WB  input  5  WB destination register.
REQ-007 write_back_data_WB  input  32  WB write data.
REQ-008 trace_en  input  1  capture enable.
REQ-009 clr_overflow  input  1  clears overflow and drop_count.
REQ-010 out_ready  input  1  consumer ready.
REQ-011 out_valid  output  1  FIFO head entry valid.
REQ-012 out_addr  output  5  head entry register address.
REQ-013 out_data  output  32  head entry data.
REQ-014 out_cycle  output  CYC_W  head entry cycle stamp.
REQ-015 count  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-016 overflow  output  1  sticky: at least one commit dropped.
REQ-017 drop_count  output  8  dropped commits, saturating.

Function
REQ-018 Cycle counter SHALL be 0 in the first cycle after reset release, increment by 1 every clock, and wrap from 2^CYC_W-1 to 0.
REQ-019 Capture condition SHALL be: reg_write_WB=1, write_register_addr_WB!=0, trace_en=1.
REQ-020 Writes to register 0 SHALL never be captured or counted as drops.
REQ-021 A captured entry SHALL be {cycle counter value in the capture cycle, addr, data}.
REQ-022 A captured entry SHALL appear at the head with out_valid=1 one cycle after the capture edge if the FIFO was empty.
REQ-023 There SHALL be no same-cycle bypass.
REQ-024 out_valid SHALL equal (count!=0).
REQ-025 out_addr, out_data and out_cycle SHALL reflect the oldest entry and be stable while out_valid=1 and out_ready=0.
REQ-026 Pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-027 Pop on empty SHALL be ignored.
REQ-028 Push and pop in the same cycle SHALL leave count unchanged, including when full; the push is accepted when full only if a pop occurs that cycle.
REQ-029 Capture when count=DEPTH with no pop SHALL drop the entry, set overflow, and increment drop_count, saturating at 255.
REQ-030 clr_overflow=1 SHALL clear overflow and drop_count to 0 on the next edge.
REQ-031 A drop coincident with clr_overflow SHALL win: overflow=1 and drop_count=1.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-033 trace_en deassertion SHALL affect capture only; draining SHALL continue.
REQ-034 Entry ordering SHALL be strict commit order.

Reset
REQ-035 While reset=0 at an edge, the following SHALL be cleared: pointers, count=0, out_valid=0, overflow=0, drop_count=0, cycle counter=0.
REQ-036 FIFO storage contents need not be cleared.
REQ-037 out_addr, out_data and out_cycle SHALL be don't-care while out_valid=0.
REQ-038 Reset asserted mid-operation SHALL discard all entries, and captures during reset SHALL be ignored.

Verification
REQ-039 Single commit: reset released, out_ready=0, then one cycle with reg_write_WB=1, addr=8, data=0x99999999 at cycle 3 -> next cycle out_valid=1, out_addr=8, out_data=0x99999999, out_cycle=3, count=1.
REQ-040 Zero-register filter: write to addr 0 with data 0x12345678 -> count stays 0, overflow=0.
REQ-041 Fill and overflow: DEPTH=16, out_ready=0, 18 consecutive commits to addr 9 -> count=16, overflow=1, drop_count=2; draining yields the first 16 data values in order.
REQ-042 Full with simultaneous push/pop: full FIFO, out_ready=1, commit in the same cycle -> count stays 16, overflow stays 0, new entry is at the tail.
REQ-043 Clear race: overflow=1, drop_count=5, then clr_overflow=1 coinciding with a dropped commit -> overflow=1, drop_count=1.
REQ-044 Reset mid-stream: 5 entries queued, reset=0 for one cycle -> count=0, out_valid=0, and the cycle stamp restarts at 0.
